// File: rtl/snoop_bus_ctrl_pkg.sv
// snoop_bus_ctrl_pkg: shared types and constants for the two-cpu snoop bus controller.
package snoop_bus_ctrl_pkg;
    localparam int BUS_ADDR_W = 11;
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_RD   = 2'b01,
        OP_WR   = 2'b10,
        OP_INV  = 2'b11
    } bus_op_t;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SNOOP,
        ST_XFER,
        ST_MEM,
        ST_INV,
        ST_DONE
    } bus_state_t;
    typedef logic [1:0] datasel_t;
    localparam datasel_t DSEL_NONE = 2'b00;
    localparam datasel_t DSEL_MEM  = 2'b01;
    localparam datasel_t DSEL_CPU  = 2'b10;
endpackage

// File: rtl/snoop_bus_ctrl_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin pick; on a tie the cpu that did not own the bus last wins.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_owner,
    input  logic       en,
    output logic       owner,
    output logic       win
);
    assign win   = en & |req;
    assign owner = &req ? ~last_owner : req[1];
endmodule

// File: rtl/snoop_bus_ctrl.sv
// snoop_bus_ctrl: round-robin coherence bus controller for two cpus, one transaction in flight.
// Optional MEM-state watchdog enabled by defining SNOOP_BUS_TIMEOUT_EN.
module snoop_bus_ctrl
    import snoop_bus_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            read_miss,
    input  logic [1:0]            write_miss,
    input  logic [1:0]            invalidate,
    input  logic [BUS_ADDR_W-1:0] BICO0,
    input  logic [BUS_ADDR_W-1:0] BICO1,
    input  logic [1:0]            cpu_search_found,
    input  logic                  u_rdy,
    output logic [1:0]            grant,
    output logic [1:0]            done,
    output logic [BUS_ADDR_W+1:0] BOCI,
    output logic [1:0]            cpu_search,
    output logic [1:0][1:0]       cpu_datasel,
    output logic [1:0]            invalidate_from_other_cpu,
    output logic                  bus_err
);
    bus_state_t            state, state_n;
    bus_op_t               op, new_op;
    logic [BUS_ADDR_W-1:0] addr;
    logic [1:0]            req;
    logic                  owner, last_owner, win, win_owner, timeout;

    assign req    = read_miss | write_miss | invalidate;
    assign new_op = write_miss[win_owner] ? OP_WR : read_miss[win_owner] ? OP_RD : OP_INV;

    rr_arbiter2 u_arb (
        .req        (req),
        .last_owner (last_owner),
        .en         (state == ST_IDLE),
        .owner      (win_owner),
        .win        (win)
    );

`ifdef SNOOP_BUS_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);
    logic [7:0] timer;
    assign timeout = state == ST_MEM && !u_rdy && timer == TIMEOUT_LIM;
    // timer sits at zero outside MEM, so it is already clear on MEM entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer   <= '0;
            bus_err <= 1'b0;
        end else begin
            timer <= (state == ST_MEM) ? timer + 8'd1 : 8'd0;
            if (timeout) bus_err <= 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout        = 1'b0;
    assign bus_err        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:  if (win) state_n = (new_op == OP_INV) ? ST_INV : ST_SNOOP;
            ST_SNOOP: state_n = cpu_search_found[~owner] ? ST_XFER : ST_MEM;
            ST_XFER:  state_n = (op == OP_WR) ? ST_INV : ST_DONE;
            ST_MEM:   state_n = timeout ? ST_DONE : !u_rdy ? ST_MEM : (op == OP_WR) ? ST_INV : ST_DONE;
            ST_INV:   state_n = ST_DONE;
            ST_DONE:  state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    // last_owner resets to 1 so cpu0 takes the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner      <= 1'b0;
            last_owner <= 1'b1;
            op         <= OP_NONE;
            addr       <= '0;
        end else if (state == ST_IDLE && win) begin
            owner      <= win_owner;
            last_owner <= win_owner;
            op         <= new_op;
            addr       <= win_owner ? BICO1 : BICO0;
        end
    end

    always_comb begin
        grant                     = '0;
        done                      = '0;
        cpu_search                = '0;
        cpu_datasel               = '0;
        invalidate_from_other_cpu = '0;
        BOCI                      = '0;
        if (state != ST_IDLE) begin
            grant[owner] = 1'b1;
            BOCI         = {op, addr};
        end
        done[owner]                       = state == ST_DONE;
        cpu_search[~owner]                = state == ST_SNOOP;
        invalidate_from_other_cpu[~owner] = state == ST_INV;
        cpu_datasel[owner]                = (state == ST_XFER) ? DSEL_CPU : (state == ST_MEM) ? DSEL_MEM : DSEL_NONE;
    end
endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// tb_snoop_bus_ctrl: directed bench; completions are checked against a queue of expected done/BOCI pairs.
module tb_snoop_bus_ctrl;
    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [1:0]      read_miss = '0, write_miss = '0, invalidate = '0, cpu_search_found = '0;
    logic [10:0]     BICO0 = '0, BICO1 = '0;
    logic            u_rdy = 1'b0;
    logic [1:0]      grant, done, cpu_search, invalidate_from_other_cpu;
    logic [12:0]     BOCI;
    logic [1:0][1:0] cpu_datasel;
    logic            bus_err;

    typedef struct packed {
        logic [1:0]  done;
        logic [12:0] boci;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_cmp = 0, n_err = 0, g0_run = 0, k;
    logic got;

    always #5 clk = ~clk;

    snoop_bus_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .read_miss                 (read_miss),
        .write_miss                (write_miss),
        .invalidate                (invalidate),
        .BICO0                     (BICO0),
        .BICO1                     (BICO1),
        .cpu_search_found          (cpu_search_found),
        .u_rdy                     (u_rdy),
        .grant                     (grant),
        .done                      (done),
        .BOCI                      (BOCI),
        .cpu_search                (cpu_search),
        .cpu_datasel               (cpu_datasel),
        .invalidate_from_other_cpu (invalidate_from_other_cpu),
        .bus_err                   (bus_err)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // advance to the next falling edge, then check invariants and the completion scoreboard
    task automatic tick;
        @(negedge clk);
        g0_run = grant[0] ? g0_run + 1 : 0;
        chk("grant_excl", 16'(&grant), 16'd0);
        if (done != 2'b00) begin
            if (sb.size() == 0) chk("sb_unexpected_done", 16'(done), 16'd0);
            else begin
                e = sb.pop_front();
                chk("sb_done", 16'(done), 16'(e.done));
                chk("sb_boci", 16'(BOCI), 16'(e.boci));
            end
        end
    endtask

    initial begin
        tick();
        chk("rst_out", {3'b0, grant, done, cpu_search, invalidate_from_other_cpu, cpu_datasel, bus_err}, 16'd0);
        chk("rst_boci", 16'(BOCI), 16'd0);
        rst_n = 1'b1;
        tick();
        // cpu0 read miss, no snoop hit, memory answers on the 4th MEM cycle
        read_miss = 2'b01; BICO0 = 11'h123; sb.push_back('{2'b01, 13'h0923});
        tick();
        chk("t1_snoop_boci", 16'(BOCI), 16'h0923);
        chk("t1_search", 16'(cpu_search), 16'b10);
        chk("t1_grant", 16'(grant), 16'b01);
        read_miss = 2'b00;
        tick();
        chk("t1_dsel_mem", 16'(cpu_datasel), 16'b0001);
        tick();
        tick();
        tick();
        chk("t1_dsel_mem4", 16'(cpu_datasel), 16'b0001);
        u_rdy = 1'b1;
        tick();
        chk("t1_done", 16'(done), 16'b01);
        chk("t1_grant_done", 16'(grant), 16'b01);
        chk("t1_grant_len", 16'(g0_run), 16'd6);
        u_rdy = 1'b0;
        tick();
        chk("t1_idle_grant", 16'(grant), 16'd0);
        chk("t1_idle_boci", 16'(BOCI), 16'd0);
        // cpu1 read miss served from cpu0's cache
        read_miss = 2'b10; BICO1 = 11'h2AA; cpu_search_found = 2'b01; sb.push_back('{2'b10, 13'h0AAA});
        tick();
        chk("t2_search", 16'(cpu_search), 16'b01);
        chk("t2_boci", 16'(BOCI), 16'h0AAA);
        read_miss = 2'b00; BICO1 = 11'h000;
        tick();
        chk("t2_dsel_cpu", 16'(cpu_datasel), 16'b1000);
        tick();
        chk("t2_done", 16'(done), 16'b10);
        cpu_search_found = 2'b00;
        tick();
        chk("t2_idle", 16'(grant), 16'd0);
        // cpu0 write miss: MEM, then invalidate cpu1, address change mid-flight ignored
        write_miss = 2'b01; BICO0 = 11'h055; sb.push_back('{2'b01, 13'h1055});
        tick();
        chk("t3_snoop_boci", 16'(BOCI), 16'h1055);
        write_miss = 2'b00; BICO0 = 11'h7FF;
        tick();
        chk("t3_dsel_mem", 16'(cpu_datasel), 16'b0001);
        chk("t3_mem_boci", 16'(BOCI), 16'h1055);
        u_rdy = 1'b1;
        tick();
        chk("t3_inv", 16'(invalidate_from_other_cpu), 16'b10);
        chk("t3_inv_boci", 16'(BOCI), 16'h1055);
        chk("t3_inv_dsel", 16'(cpu_datasel), 16'd0);
        u_rdy = 1'b0;
        tick();
        chk("t3_done", 16'(done), 16'b01);
        chk("t3_inv_off", 16'(invalidate_from_other_cpu), 16'd0);
        chk("t3_done_boci", 16'(BOCI), 16'h1055);
        tick();
        // both cpus request continuously from reset: owners must alternate starting with cpu0
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        read_miss = 2'b11; BICO0 = 11'h100; BICO1 = 11'h200; u_rdy = 1'b1;
        for (int i = 0; i < 4; i++) sb.push_back(i[0] ? '{2'b10, 13'h0A00} : '{2'b01, 13'h0900});
        k = 0;
        for (int i = 0; i < 40 && k < 4; i++) begin
            tick();
            if (done != 2'b00) begin
                chk("t4_alt_owner", 16'(done), k[0] ? 16'b10 : 16'b01);
                k++;
            end
        end
        chk("t4_count", 16'(k), 16'd4);
        read_miss = 2'b00; u_rdy = 1'b0;
        tick();
        tick();
        chk("t4_idle", 16'(grant), 16'd0);
        // cpu0 invalidate only: straight to INV, no snoop
        invalidate = 2'b01; BICO0 = 11'h3C3; sb.push_back('{2'b01, 13'h1BC3});
        tick();
        chk("t5_inv", 16'(invalidate_from_other_cpu), 16'b10);
        chk("t5_no_search", 16'(cpu_search), 16'd0);
        chk("t5_boci", 16'(BOCI), 16'h1BC3);
        invalidate = 2'b00;
        tick();
        chk("t5_done", 16'(done), 16'b01);
        chk("t5_no_search2", 16'(cpu_search), 16'd0);
        tick();
        chk("t5_idle_boci", 16'(BOCI), 16'd0);
        // memory never answers
        read_miss = 2'b10; BICO1 = 11'h001;
`ifdef SNOOP_BUS_TIMEOUT_EN
        sb.push_back('{2'b10, 13'h0801});
        tick();
        read_miss = 2'b00;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            tick();
            got = done != 2'b00;
        end
        chk("t6_timeout_done", 16'(got), 16'd1);
        chk("t6_bus_err", 16'(bus_err), 16'd1);
        tick();
        tick();
        chk("t6_bus_err_sticky", 16'(bus_err), 16'd1);
        chk("t6_idle", 16'(grant), 16'd0);
`else
        tick();
        read_miss = 2'b00;
        repeat (20) tick();
        chk("t6_still_mem", 16'(cpu_datasel), 16'b0100);
        chk("t6_no_err", 16'(bus_err), 16'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
`endif
        // asynchronous reset while in MEM
        read_miss = 2'b01; BICO0 = 11'h0AB;
        tick();
        read_miss = 2'b00;
        tick();
        chk("t7_mem", 16'(cpu_datasel), 16'b0001);
        chk("t7_grant", 16'(grant), 16'b01);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_async_out", {3'b0, grant, done, cpu_search, invalidate_from_other_cpu, cpu_datasel, bus_err}, 16'd0);
        chk("t7_async_boci", 16'(BOCI), 16'd0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("t7_idle", 16'(grant), 16'd0);
        chk("t7_idle_boci", 16'(BOCI), 16'd0);
        chk("sb_left", 16'(sb.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
